// File: rtl/reservation_station.sv
// Tomasulo reservation station: per-entry IDLE/WAIT/READY/EXEC tracking, CDB snoop, single-FU dispatch.
// Optional RS_AGE_PRIO_EN: dispatch picks the oldest READY entry instead of the lowest index.
//
// state | meaning
// IDLE  | entry free, may be allocated on issue
// WAIT  | allocated, at least one operand still pending on a CDB tag
// READY | both operands valid, waiting for the functional unit
// EXEC  | dispatched, held until its own tag appears on the CDB
module reservation_station #(
  parameter int NUM_ENTRIES = 3,
  parameter int BASE_TAG    = 1,
  parameter int TAG_W       = 4,
  parameter int DATA_W      = 16,
  parameter int OP_W        = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_vk,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [OP_W-1:0]   disp_op,
  output logic [DATA_W-1:0] disp_a,
  output logic [DATA_W-1:0] disp_b,
  output logic [TAG_W-1:0]  disp_tag
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_EXEC  = 2'd3
  } state_t;

  state_t            r_state     [NUM_ENTRIES];
  state_t            w_state_nxt [NUM_ENTRIES];
  logic [OP_W-1:0]   r_op        [NUM_ENTRIES];
  logic [TAG_W-1:0]  r_qj        [NUM_ENTRIES];
  logic [DATA_W-1:0] r_vj        [NUM_ENTRIES];
  logic [TAG_W-1:0]  r_qk        [NUM_ENTRIES];
  logic [DATA_W-1:0] r_vk        [NUM_ENTRIES];

  logic                   w_issue_ready;
  logic [IDX_W-1:0]       w_issue_idx;
  logic                   w_issue_fire;
  logic                   w_disp_valid;
  logic [IDX_W-1:0]       w_disp_idx;
  logic                   w_disp_fire;
  logic                   w_byp_j;
  logic                   w_byp_k;
  logic [TAG_W-1:0]       w_in_qj;
  logic [TAG_W-1:0]       w_in_qk;
  logic [DATA_W-1:0]      w_in_vj;
  logic [DATA_W-1:0]      w_in_vk;
  logic [NUM_ENTRIES-1:0] w_snp_j;
  logic [NUM_ENTRIES-1:0] w_snp_k;

`ifdef RS_AGE_PRIO_EN
  logic [3:0] r_seq [NUM_ENTRIES];
  logic [3:0] r_seq_ctr;

  // Sequence numbers wrap; with at most 8 entries in flight the signed difference is unambiguous.
  function automatic logic seq_older(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    d = a - b;
    return d[3];
  endfunction
`endif

  // Allocation: lowest-index IDLE entry
  always_comb begin
    w_issue_ready = 1'b0;
    w_issue_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_state[i] == ST_IDLE) begin
        w_issue_ready = 1'b1;
        w_issue_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_disp_valid = 1'b0;
    w_disp_idx   = '0;
`ifdef RS_AGE_PRIO_EN
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (r_state[i] == ST_READY &&
          (!w_disp_valid || seq_older(r_seq[i], r_seq[w_disp_idx]))) begin
        w_disp_valid = 1'b1;
        w_disp_idx   = IDX_W'(i);
      end
    end
`else
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_state[i] == ST_READY) begin
        w_disp_valid = 1'b1;
        w_disp_idx   = IDX_W'(i);
      end
    end
`endif
  end

  assign w_issue_fire = issue_valid && w_issue_ready;
  assign w_disp_fire  = w_disp_valid && disp_ready;

  // A producer broadcasting in the issue cycle would otherwise be missed forever
  assign w_byp_j = cdb_valid && (issue_qj != '0) && (cdb_tag == issue_qj);
  assign w_byp_k = cdb_valid && (issue_qk != '0) && (cdb_tag == issue_qk);
  assign w_in_qj = w_byp_j ? '0 : issue_qj;
  assign w_in_qk = w_byp_k ? '0 : issue_qk;
  assign w_in_vj = w_byp_j ? cdb_data : issue_vj;
  assign w_in_vk = w_byp_k ? cdb_data : issue_vk;

  always_comb begin
    w_snp_j = '0;
    w_snp_k = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_snp_j[i] = cdb_valid && (cdb_tag != '0) && (r_state[i] == ST_WAIT) && (r_qj[i] == cdb_tag);
      w_snp_k[i] = cdb_valid && (cdb_tag != '0) && (r_state[i] == ST_WAIT) && (r_qk[i] == cdb_tag);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        ST_IDLE: begin
          if (w_issue_fire && w_issue_idx == IDX_W'(i)) begin
            if (w_in_qj == '0 && w_in_qk == '0) w_state_nxt[i] = ST_READY;
            else                                w_state_nxt[i] = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if ((r_qj[i] == '0 || w_snp_j[i]) && (r_qk[i] == '0 || w_snp_k[i]))
            w_state_nxt[i] = ST_READY;
        end
        ST_READY: begin
          if (w_disp_fire && w_disp_idx == IDX_W'(i)) w_state_nxt[i] = ST_EXEC;
        end
        ST_EXEC: begin
          if (cdb_valid && cdb_tag == TAG_W'(BASE_TAG + i)) w_state_nxt[i] = ST_IDLE;
        end
        default: w_state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_state[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_state[i] <= w_state_nxt[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_op[i] <= '0;
        r_qj[i] <= '0;
        r_vj[i] <= '0;
        r_qk[i] <= '0;
        r_vk[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_issue_fire && w_issue_idx == IDX_W'(i)) begin
          r_op[i] <= issue_op;
          r_qj[i] <= w_in_qj;
          r_vj[i] <= w_in_vj;
          r_qk[i] <= w_in_qk;
          r_vk[i] <= w_in_vk;
        end else begin
          if (w_snp_j[i]) begin
            r_qj[i] <= '0;
            r_vj[i] <= cdb_data;
          end
          if (w_snp_k[i]) begin
            r_qk[i] <= '0;
            r_vk[i] <= cdb_data;
          end
        end
      end
    end
  end

`ifdef RS_AGE_PRIO_EN
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_seq_ctr <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) r_seq[i] <= '0;
    end else if (w_issue_fire) begin
      r_seq_ctr <= r_seq_ctr + 4'd1;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_issue_idx == IDX_W'(i)) r_seq[i] <= r_seq_ctr;
      end
    end
  end
`endif

  assign issue_ready = w_issue_ready;
  assign issue_tag   = w_issue_ready ? TAG_W'(BASE_TAG) + TAG_W'(w_issue_idx) : TAG_W'(BASE_TAG);

  assign disp_valid = w_disp_valid;
  assign disp_op    = w_disp_valid ? r_op[w_disp_idx] : '0;
  assign disp_a     = w_disp_valid ? r_vj[w_disp_idx] : '0;
  assign disp_b     = w_disp_valid ? r_vk[w_disp_idx] : '0;
  assign disp_tag   = w_disp_valid ? TAG_W'(BASE_TAG) + TAG_W'(w_disp_idx) : '0;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue, CDB bypass/snoop, full, CLR and dispatch ordering.
module tb_reservation_station;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_op;
  logic [3:0]  issue_qj;
  logic [15:0] issue_vj;
  logic [3:0]  issue_qk;
  logic [15:0] issue_vk;
  logic [3:0]  issue_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        disp_valid;
  logic        disp_ready;
  logic [2:0]  disp_op;
  logic [15:0] disp_a;
  logic [15:0] disp_b;
  logic [3:0]  disp_tag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  reservation_station #(
    .NUM_ENTRIES(3), .BASE_TAG(1), .TAG_W(4), .DATA_W(16), .OP_W(3)
  ) dut (
    .CLK(CLK), .CLR(CLR),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_qj(issue_qj), .issue_vj(issue_vj), .issue_qk(issue_qk), .issue_vk(issue_vk),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_a(disp_a), .disp_b(disp_b), .disp_tag(disp_tag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    disp_ready  = 1'b0;
  endtask

  task automatic drive_issue(input logic [2:0] op, input logic [3:0] qj, input logic [15:0] vj,
                             input logic [3:0] qk, input logic [15:0] vk);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_qj    = qj;
    issue_vj    = vj;
    issue_qk    = qk;
    issue_vk    = vk;
  endtask

  task automatic drive_cdb(input logic [3:0] tag, input logic [15:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  // Dispatch the currently selected entry, then broadcast its own tag to free it
  task automatic retire(input logic [3:0] tag);
    disp_ready = 1'b1;
    tick();
    clear_inputs();
    drive_cdb(tag, 16'h0);
    tick();
    clear_inputs();
  endtask

  initial begin
    CLR = 1'b1;
    clear_inputs();
    issue_op = '0; issue_qj = '0; issue_vj = '0; issue_qk = '0; issue_vk = '0;
    cdb_tag = '0; cdb_data = '0;
    tick();
    tick();
    CLR = 1'b0;

    check("rst_issue_ready", issue_ready, 1);
    check("rst_issue_tag",   issue_tag,   1);
    check("rst_disp_valid",  disp_valid,  0);
    check("rst_disp_op",     disp_op,     0);
    check("rst_disp_a",      disp_a,      0);
    check("rst_disp_b",      disp_b,      0);
    check("rst_disp_tag",    disp_tag,    0);

    // Ready-at-issue entry dispatches the next cycle
    drive_issue(3'd2, 4'd0, 16'd5, 4'd0, 16'd7);
    check("t1_issue_tag", issue_tag, 1);
    tick();
    clear_inputs();
    check("t1_disp_valid", disp_valid, 1);
    check("t1_disp_op",    disp_op,    2);
    check("t1_disp_a",     disp_a,     5);
    check("t1_disp_b",     disp_b,     7);
    check("t1_disp_tag",   disp_tag,   1);
    check("t1_next_tag",   issue_tag,  2);
    disp_ready = 1'b1;
    tick();
    clear_inputs();
    check("t1_exec_valid", disp_valid, 0);
    check("t1_exec_tag",   disp_tag,   0);
    drive_cdb(4'd1, 16'h1234);
    tick();
    clear_inputs();
    check("t1_freed_tag", issue_tag, 1);

    // Operand resolved by CDB snoop; tag 4 belongs to no entry here
    drive_issue(3'd3, 4'd4, 16'hDEAD, 4'd0, 16'd3);
    tick();
    clear_inputs();
    check("t2_wait_valid", disp_valid, 0);
    drive_cdb(4'd4, 16'h00AA);
    check("t2_same_cycle_valid", disp_valid, 0);
    tick();
    clear_inputs();
    check("t2_disp_valid", disp_valid, 1);
    check("t2_disp_a",     disp_a,     16'h00AA);
    check("t2_disp_b",     disp_b,     3);
    check("t2_disp_tag",   disp_tag,   1);
    retire(4'd1);

    // Issue-cycle bypass
    drive_issue(3'd1, 4'd6, 16'd0, 4'd0, 16'd1);
    drive_cdb(4'd6, 16'd9);
    tick();
    clear_inputs();
    check("t3_disp_valid", disp_valid, 1);
    check("t3_disp_a",     disp_a,     9);
    check("t3_disp_b",     disp_b,     1);
    retire(4'd1);

    // Both operands waiting on the same producer
    drive_issue(3'd2, 4'd5, 16'd0, 4'd5, 16'd0);
    tick();
    clear_inputs();
    check("t3b_wait_valid", disp_valid, 0);
    drive_cdb(4'd5, 16'h0055);
    tick();
    clear_inputs();
    check("t3b_disp_a", disp_a, 16'h0055);
    check("t3b_disp_b", disp_b, 16'h0055);
    retire(4'd1);
    check("t3b_free_tag", issue_tag, 1);

    // Fill: tag1 waits on tag 9 (never broadcast), tags 2 and 3 ready
    drive_issue(3'd1, 4'd9, 16'h0011, 4'd0, 16'd0);
    check("t4_tag1", issue_tag, 1);
    tick();
    drive_issue(3'd2, 4'd0, 16'h0022, 4'd0, 16'd0);
    check("t4_tag2", issue_tag, 2);
    tick();
    drive_issue(3'd3, 4'd0, 16'h0033, 4'd0, 16'd0);
    check("t4_tag3", issue_tag, 3);
    tick();
    drive_issue(3'd7, 4'd0, 16'h0077, 4'd0, 16'd0);
    check("t4_full_ready", issue_ready, 0);
    check("t4_full_tag",   issue_tag,   1);
    tick();
    clear_inputs();
    check("t4_still_full", issue_ready, 0);
    check("t4_sel_tag",    disp_tag,    2);
    check("t4_sel_op",     disp_op,     2);
    check("t4_sel_a",      disp_a,      16'h0022);
    disp_ready = 1'b1;
    tick();
    clear_inputs();
    check("t4_next_sel", disp_tag, 3);
    drive_cdb(4'd2, 16'h0);
    check("t4_no_same_cycle_free", issue_ready, 0);
    tick();
    clear_inputs();
    check("t4_freed_ready", issue_ready, 1);
    check("t4_freed_tag",   issue_tag,   2);
    disp_ready = 1'b1;
    tick();
    clear_inputs();
    check("t4_only_wait", disp_valid, 0);

    // CLR with entries in WAIT (tag1) and EXEC (tag3)
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check("clr_issue_ready", issue_ready, 1);
    check("clr_issue_tag",   issue_tag,   1);
    check("clr_disp_valid",  disp_valid,  0);
    drive_cdb(4'd3, 16'hBEEF);
    tick();
    drive_cdb(4'd9, 16'hBEEF);
    tick();
    clear_inputs();
    check("clr_stale_tag",   issue_tag,  1);
    check("clr_stale_valid", disp_valid, 0);

    // Ordering: tag3 becomes older than a re-issued tag1
    drive_issue(3'd4, 4'd0, 16'h0010, 4'd0, 16'd0);
    tick();
    drive_issue(3'd5, 4'd12, 16'h0020, 4'd0, 16'd0);
    tick();
    drive_issue(3'd6, 4'd0, 16'h0030, 4'd0, 16'd0);
    tick();
    clear_inputs();
    check("t5_first_sel", disp_tag, 1);
    disp_ready = 1'b1;
    tick();
    clear_inputs();
    check("t5_after_disp", disp_tag, 3);
    drive_cdb(4'd1, 16'h0);
    tick();
    clear_inputs();
    drive_issue(3'd7, 4'd0, 16'h0070, 4'd0, 16'd0);
    tick();
    clear_inputs();
    disp_ready = 1'b1;
`ifdef RS_AGE_PRIO_EN
    check("t5_order0", disp_tag, 3);
    tick();
    check("t5_order1", disp_tag, 1);
`else
    check("t5_order0", disp_tag, 1);
    tick();
    check("t5_order1", disp_tag, 3);
`endif
    tick();
    clear_inputs();
    check("t5_drained", disp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Tomasulo reservation station directly downstream of the register file.
- Consumes per-operand dependency tag / data pairs read at issue. Allocates its own tag, which the register file records as the destination dependency.
- Snoops the CDB to resolve pending operands and dispatches ready entries to one functional unit.
- Entries stay allocated until their own result appears on the CDB, so a tag is never reused while still in flight.

Parameters:
- NUM_ENTRIES, 3, number of station entries (1..8)
- BASE_TAG, 1, tag of entry 0; entry i owns tag BASE_TAG+i. Must be nonzero, and BASE_TAG+NUM_ENTRIES-1 must be <= 15.
- TAG_W, 4, tag width; tag 0 means "no dependency"
- DATA_W, 16, operand/result width
- OP_W, 3, opcode width

Ports:
- CLK  in  1  clock, rising edge
- CLR  in  1  reset, synchronous, active-high
- issue_valid  in  1  issue request
- issue_ready  out  1  a free entry exists
- issue_op  in  OP_W  opcode
- issue_qj  in  TAG_W  operand A dependency (0 = value valid)
- issue_vj  in  DATA_W  operand A value
- issue_qk  in  TAG_W  operand B dependency
- issue_vk  in  DATA_W  operand B value
- issue_tag  out  TAG_W  tag to be allocated (valid when issue_ready)
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  CDB producer tag
- cdb_data  in  DATA_W  CDB result
- disp_valid  out  1  an entry is ready for the functional unit
- disp_ready  in  1  functional unit accepts
- disp_op  out  OP_W  dispatched opcode
- disp_a  out  DATA_W  operand A
- disp_b  out  DATA_W  operand B
- disp_tag  out  TAG_W  tag of the dispatched entry

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - CLR (sync) sets every entry to IDLE and clears Q/V/op fields to 0. This also applies mid-operation: in-flight entries are dropped with no dispatch.
  - Outputs after reset: issue_ready=1, issue_tag=BASE_TAG, disp_valid=0, disp_op/disp_a/disp_b/disp_tag=0.
- Per-entry state machine (IDLE, WAIT, READY, EXEC):
  - IDLE -> WAIT/READY on issue. READY if both Q fields are 0 after CDB bypass, else WAIT.
  - WAIT -> READY at the edge where the last nonzero Q field is cleared by a CDB match.
  - READY -> EXEC at the edge where disp_valid && disp_ready and the entry is selected.
  - EXEC -> IDLE at the edge where cdb_valid && cdb_tag == own tag.
- Issue:
  - issue_ready = any entry IDLE (combinational from current state).
  - Allocation goes to the lowest-index IDLE entry; issue_tag = BASE_TAG+index.
  - A transfer occurs when issue_valid && issue_ready. issue_valid while !issue_ready is ignored.
- Issue-cycle CDB bypass: if cdb_valid, issue_qj != 0 and cdb_tag == issue_qj, store Vj=cdb_data and Qj=0. Same rule applies to the k operand.
- CDB snoop: every WAIT entry with Qj==cdb_tag (or Qk==cdb_tag), where the tag is nonzero, captures cdb_data and clears that Q field. Both operands may match the same broadcast.
- CDB tag handling:
  - cdb_tag 0 is ignored entirely.
  - Tags outside this station's range free nothing but still resolve operands.
- Dispatch selection and outputs:
  - disp_valid = any entry READY. Default selection is the lowest-index READY entry.
  - disp_* outputs are combinational from the selected entry. They are 0 when disp_valid=0.
  - disp_valid may stay high with disp_ready low. Outputs hold as long as the same entry remains selected.
- Latency:
  - An issued entry can dispatch no earlier than the cycle after issue.
  - An entry freed by the CDB is reusable the cycle after the broadcast. issue_ready does not reflect a same-cycle free.
- Simultaneous events in one cycle (issue, CDB capture, dispatch, free on different entries) are all honoured. One issue and one dispatch occur per cycle at most.
- Full: all entries non-IDLE -> issue_ready=0, issue_tag holds BASE_TAG.

Optional Feature:
- RS_AGE_PRIO_EN
- Defined:
  - Each entry stores a 4-bit issue sequence number from a wrapping counter that increments on each issue.
  - Dispatch selects the oldest READY entry by wrap-aware sequence comparison. The counter is cleared by CLR.
- Undefined: lowest-index READY entry wins; no sequence storage.

Test Plan:
- Reset then issue op=2, qj=0 vj=5, qk=0 vk=7 -> issue_tag=1. Next cycle disp_valid=1, disp_a=5, disp_b=7, disp_tag=1. With disp_ready=1 the entry goes to EXEC and disp_valid drops.
- Issue qj=4 vj=x, qk=0 vk=3. Then cdb_valid, tag=4, data=0x00AA -> entry READY the next cycle, disp_a=0x00AA, disp_b=3.
- Issue with qj=6 while cdb_valid, tag=6, data=9 in the same cycle -> bypass captures 9. disp_valid=1 the next cycle.
- Fill all 3 entries (tags 1,2,3) -> issue_ready=0 and a further issue_valid is ignored. Dispatch tag 2, then CDB tag=2 -> issue_ready=1 the next cycle, issue_tag=2.
- Two READY entries (index 2 issued first, then index 0), disp_ready=1 -> default dispatch order is tag 1 then tag 3. With RS_AGE_PRIO_EN the order is tag 3 then tag 1.
- CLR asserted while entries are in WAIT and EXEC -> next cycle issue_ready=1, disp_valid=0. A later CDB with a stale tag has no effect.
